timer_interrupt_controller: RTL and testbench
=============================================

# timer_interrupt_controller

Consumer side of the timer interrupt flag/mask registers. Continuously evaluates the pending timer interrupts (flag AND mask), gated by the CPU global interrupt enable. Selects the highest-priority source and presents a vector request to the CPU core through a req/ack handshake. On acknowledge it issues a one-cycle hardware-clear pulse back to the flag register, matching ATmega32A behaviour where TOVn/OCFn/ICF1 clear when the vector is taken.

## Interface
Parameters:
- VEC_BASE, 8'h08: word address of the highest-priority timer vector (TIMER2_COMP); each lower-priority source is +2.
- HOLDOFF_CYCLES, 1: idle cycles after a clear pulse before re-arbitration, range 1–3.

Ports:
- sysClock  in  1  system clock; all state updates on the rising edge.
- system_reset  in  1  asynchronous, active-low reset.
- tifr_in  in  8  flag register contents: [7]OCF2 [6]TOV2 [5]ICF1 [4]OCF1A [3]OCF1B [2]TOV1 [1]OCF0 [0]TOV0.
- timsk_in  in  8  mask register contents, same bit layout.
- global_en  in  1  SREG I-bit from the core.
- irq_ack  in  1  core accepts the presented vector; single-cycle pulse.
- irq_req  out  1  interrupt request to the core; registered.
- vector_addr  out  8  word address of the requested vector; registered; valid while irq_req=1.
- flag_clear  out  8  one-hot hardware-clear pulse to the flag register, same bit layout.
- pending  out  1  combinational OR of (tifr_in & timsk_in); ignores global_en.

## Operation
- Reset values: irq_req=0, vector_addr=8'h00, flag_clear=8'h00, state=IDLE, latched index=0.
- Priority is fixed: bit 7 is highest, bit 0 is lowest. vector_addr = VEC_BASE + 2*(7-idx). With the default, OCF2→0x08 and TOV0→0x16.
- IDLE: if global_en=1 and (tifr_in & timsk_in)≠0, latch the highest set idx, set irq_req=1 and vector_addr, and go to REQUEST. Otherwise stay.
- REQUEST: vector_addr and idx are frozen. A new higher-priority flag does not preempt.
  - irq_ack=1: irq_req←0, flag_clear←one-hot(idx), go to CLEAR.
  - Otherwise, if global_en=0 or the latched bit of (tifr_in & timsk_in)=0 (software cleared or masked it): withdraw. irq_req←0, go to IDLE, no clear pulse.
  - irq_ack takes precedence over a withdraw condition in the same cycle.
- CLEAR: flag_clear is high for exactly this one cycle, then forced to 0. Go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES cycles with outputs idle, then go to IDLE. This lets the cleared flag propagate back on tifr_in.
- irq_ack in IDLE, CLEAR or HOLDOFF is ignored and produces no side effects.
- A flag rising again during CLEAR/HOLDOFF stays pending and is served on the next IDLE evaluation.
- Reset asserted in any state immediately returns all outputs and state to their reset values. No clear pulse is emitted.

## Timing
- Flag and mask set, global_en=1, in the cycle before edge N: irq_req=1 with valid vector_addr from edge N (1-cycle latency).
- irq_ack sampled at edge M: irq_req=0 and flag_clear one-hot from edge M, flag_clear=0 from edge M+1.
- With HOLDOFF_CYCLES=1: IDLE at edge M+2, earliest next irq_req at edge M+3.
- Withdraw: irq_req falls at the edge following the condition. Re-request is possible one cycle later.
- flag_clear is never asserted for more than one cycle, never has more than one bit set, and is never asserted while irq_req=1.

## Structure
- Shared package timer_irq_pkg holds:
  - TIFR/TIMSK bit-position constants (OCF2_BIT … TOV0_BIT);
  - the state encoding (IDLE, REQUEST, CLEAR, HOLDOFF, 2 bits);
  - the default VEC_BASE.
- One sub-module, timer_irq_priority_encoder: combinational 8→3 highest-set-bit encoder with a valid output. It is instantiated once on (tifr_in & timsk_in).
- The FSM, the holdoff counter and the output registers live in timer_interrupt_controller.

## Test plan
- Single source: tifr=8'h01, timsk=8'h01, global_en=1 → irq_req next cycle with vector_addr=0x16. Ack → flag_clear=8'h01 for exactly one cycle.
- Priority: tifr=8'h91, timsk=8'hFF → vector 0x08 and clear 8'h80. Drop bit7 on tifr after the clear → the next request is 0x0E (OCF1A), then 0x16.
- Mask/global gating: tifr=8'h04, timsk=8'h00, or global_en=0 → irq_req stays 0 while pending=1 (masked case 0).
- Withdraw: in REQUEST, drop tifr bit → irq_req falls with no flag_clear. Repeat with irq_ack in the same cycle → clear pulse issued.
- No preemption and holdoff: in REQUEST for 0x16, raise OCF2 → vector stays 0x16 until ack. After ack, 0x08 appears exactly HOLDOFF_CYCLES+2 cycles later.
- Async reset asserted mid-REQUEST and mid-CLEAR → irq_req=0, flag_clear=0, vector_addr=0 immediately. Normal operation resumes after release.

Source files
------------

// File: rtl/timer_irq_pkg.sv
// Shared constants and types for the timer interrupt controller: flag/mask bit
// positions, FSM state encoding and vector address helper.
package timer_irq_pkg;

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 2;

  // TIFR/TIMSK bit positions, highest priority first
  localparam int unsigned OCF2_BIT  = 7;
  localparam int unsigned TOV2_BIT  = 6;
  localparam int unsigned ICF1_BIT  = 5;
  localparam int unsigned OCF1A_BIT = 4;
  localparam int unsigned OCF1B_BIT = 3;
  localparam int unsigned TOV1_BIT  = 2;
  localparam int unsigned OCF0_BIT  = 1;
  localparam int unsigned TOV0_BIT  = 0;

  localparam logic [7:0] DEFAULT_VEC_BASE = 8'h08;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    CLEAR   = 2'd2,
    HOLDOFF = 2'd3
  } tic_state_e;

  // Bit 7 maps to base, each lower bit adds 2 words: 2*(7-idx) == {~idx,0}
  function automatic logic [7:0] vector_of(input logic [7:0] base,
                                           input logic [IDX_W-1:0] idx);
    return base + 8'({~idx, 1'b0});
  endfunction

endpackage

// File: rtl/timer_irq_priority_encoder.sv
// Fixed-priority 8->3 encoder: reports the highest set bit and whether any bit is set.
module timer_irq_priority_encoder
  import timer_irq_pkg::*;
(
  input  logic [TIMER_W-1:0] bits,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |bits;
    if      (bits[OCF2_BIT])  idx = IDX_W'(OCF2_BIT);
    else if (bits[TOV2_BIT])  idx = IDX_W'(TOV2_BIT);
    else if (bits[ICF1_BIT])  idx = IDX_W'(ICF1_BIT);
    else if (bits[OCF1A_BIT]) idx = IDX_W'(OCF1A_BIT);
    else if (bits[OCF1B_BIT]) idx = IDX_W'(OCF1B_BIT);
    else if (bits[TOV1_BIT])  idx = IDX_W'(TOV1_BIT);
    else if (bits[OCF0_BIT])  idx = IDX_W'(OCF0_BIT);
    else if (bits[TOV0_BIT])  idx = IDX_W'(TOV0_BIT);
  end

endmodule

// File: rtl/timer_interrupt_controller.sv
// Arbitrates pending timer interrupts, requests a vector from the core and
// pulses a hardware clear of the served flag when the core acknowledges.
module timer_interrupt_controller
  import timer_irq_pkg::*;
#(
  parameter logic [7:0]  VEC_BASE       = DEFAULT_VEC_BASE,
  parameter int unsigned HOLDOFF_CYCLES = 1
) (
  input  logic               sysClock,
  input  logic               system_reset,
  input  logic [TIMER_W-1:0] tifr_in,
  input  logic [TIMER_W-1:0] timsk_in,
  input  logic               global_en,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [7:0]         vector_addr,
  output logic [TIMER_W-1:0] flag_clear,
  output logic               pending
);

  tic_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_req_d;
  logic [7:0]         vector_d;
  logic [TIMER_W-1:0] flag_clear_d;

  logic [TIMER_W-1:0] active;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;

  assign active  = tifr_in & timsk_in;
  assign pending = |active;

  timer_irq_priority_encoder u_prio (
    .bits  (active),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      irq_req     <= 1'b0;
      vector_addr <= 8'h00;
      flag_clear  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      irq_req     <= irq_req_d;
      vector_addr <= vector_d;
      flag_clear  <= flag_clear_d;
    end
  end

  // Next state and next register values; clear pulse defaults to off every cycle
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    irq_req_d    = irq_req;
    vector_d     = vector_addr;
    flag_clear_d = '0;
    unique case (state_q)
      IDLE: begin
        irq_req_d = 1'b0;
        if (global_en && enc_valid) begin
          idx_d     = enc_idx;
          irq_req_d = 1'b1;
          vector_d  = vector_of(VEC_BASE, enc_idx);
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        // Ack wins over a simultaneous withdraw; no preemption while waiting
        if (irq_ack) begin
          irq_req_d    = 1'b0;
          flag_clear_d = TIMER_W'(1) << idx_q;
          state_d      = CLEAR;
        end else if (!global_en || !active[idx_q]) begin
          irq_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      CLEAR: begin
        irq_req_d = 1'b0;
        cnt_d     = CNT_W'(HOLDOFF_CYCLES - 1);
        state_d   = HOLDOFF;
      end
      HOLDOFF: begin
        irq_req_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        irq_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_interrupt_controller.sv
// Directed bench for timer_interrupt_controller with a cycle-level reference model
// and per-cycle output comparison.
module tb_timer_interrupt_controller;

  localparam logic [7:0] VB = 8'h08;
  localparam int         HO = 1;

  logic       sysClock = 1'b0;
  logic       system_reset;
  logic [7:0] tifr_in, timsk_in;
  logic       global_en, irq_ack;
  logic       irq_req, pending;
  logic [7:0] vector_addr, flag_clear;

  int vectors_applied = 0;
  int miscompares     = 0;
  bit run_cmp         = 1'b0;

  timer_interrupt_controller #(.VEC_BASE(VB), .HOLDOFF_CYCLES(HO)) dut (
    .sysClock     (sysClock),
    .system_reset (system_reset),
    .tifr_in      (tifr_in),
    .timsk_in     (timsk_in),
    .global_en    (global_en),
    .irq_ack      (irq_ack),
    .irq_req      (irq_req),
    .vector_addr  (vector_addr),
    .flag_clear   (flag_clear),
    .pending      (pending)
  );

  always #5 sysClock = ~sysClock;

  // Reference model: request flag, served index, clear pulse, lockout cycles left
  logic       m_req;
  logic [7:0] m_vec, m_clr;
  int         m_idx, m_lock;

  function automatic int highest(input logic [7:0] v);
    int h = 0;
    for (int i = 0; i < 8; i++) if (v[i]) h = i;
    return h;
  endfunction

  always @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      m_req <= 1'b0; m_vec <= 8'h00; m_clr <= 8'h00; m_idx <= 0; m_lock <= 0;
    end else if (m_req) begin
      if (irq_ack) begin
        m_req  <= 1'b0;
        m_clr  <= 8'h01 << m_idx;
        m_lock <= HO + 1;
      end else begin
        m_clr <= 8'h00;
        if (!global_en || (((tifr_in & timsk_in) >> m_idx) & 8'h01) == 8'h00) m_req <= 1'b0;
      end
    end else begin
      m_clr <= 8'h00;
      if (m_lock > 0) m_lock <= m_lock - 1;
      else if (global_en && (tifr_in & timsk_in) != 8'h00) begin
        m_req <= 1'b1;
        m_idx <= highest(tifr_in & timsk_in);
        m_vec <= 8'(int'(VB) + 2 * (7 - highest(tifr_in & timsk_in)));
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge sysClock) begin
    if (run_cmp) begin
      check("cyc_irq_req", 8'(irq_req), 8'(m_req));
      check("cyc_flag_clear", flag_clear, m_clr);
      check("cyc_pending", 8'(pending), 8'((tifr_in & timsk_in) != 8'h00));
      if (m_req) check("cyc_vector", vector_addr, m_vec);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge sysClock); #1; end
  endtask

  initial begin
    system_reset = 1'b0;
    tifr_in = 8'h00; timsk_in = 8'h00; global_en = 1'b0; irq_ack = 1'b0;
    tick(2);
    run_cmp = 1'b1;
    check("rst_irq_req", 8'(irq_req), 8'h00);
    check("rst_vector", vector_addr, 8'h00);
    check("rst_clear", flag_clear, 8'h00);
    system_reset = 1'b1;
    tick(2);

    // Single source TOV0
    tifr_in = 8'h01; timsk_in = 8'h01; global_en = 1'b1;
    tick(1);
    check("single_req", 8'(irq_req), 8'h01);
    check("single_vec", vector_addr, 8'h16);
    irq_ack = 1'b1;
    tick(1);
    check("single_clr", flag_clear, 8'h01);
    check("single_req_low", 8'(irq_req), 8'h00);
    irq_ack = 1'b0; tifr_in = 8'h00;
    tick(1);
    check("single_clr_off", flag_clear, 8'h00);
    tick(3);

    // Priority: OCF2 first, then OCF1A, then TOV0
    tifr_in = 8'h91; timsk_in = 8'hFF;
    tick(1);
    check("prio_vec08", vector_addr, 8'h08);
    irq_ack = 1'b1; tick(1);
    check("prio_clr80", flag_clear, 8'h80);
    irq_ack = 1'b0; tifr_in = 8'h11;
    tick(3);
    check("prio_vec0e", vector_addr, 8'h0E);
    irq_ack = 1'b1; tick(1);
    check("prio_clr10", flag_clear, 8'h10);
    irq_ack = 1'b0; tifr_in = 8'h01;
    tick(3);
    check("prio_vec16", vector_addr, 8'h16);
    irq_ack = 1'b1; tick(1);
    irq_ack = 1'b0; tifr_in = 8'h00;
    tick(4);

    // Gating by mask and global enable
    tifr_in = 8'h04; timsk_in = 8'h00;
    tick(3);
    check("masked_req", 8'(irq_req), 8'h00);
    check("masked_pending", 8'(pending), 8'h00);
    timsk_in = 8'h04; global_en = 1'b0;
    tick(3);
    check("gie_off_req", 8'(irq_req), 8'h00);
    check("gie_off_pending", 8'(pending), 8'h01);
    global_en = 1'b1;
    tick(1);
    check("tov1_vec", vector_addr, 8'h12);

    // Withdraw without ack, then withdraw coinciding with ack
    tifr_in = 8'h00; tick(1);
    check("withdraw_req", 8'(irq_req), 8'h00);
    check("withdraw_clr", flag_clear, 8'h00);
    tifr_in = 8'h04; tick(1);
    check("rereq", 8'(irq_req), 8'h01);
    tifr_in = 8'h00; irq_ack = 1'b1; tick(1);
    check("ack_wins_clr", flag_clear, 8'h04);
    irq_ack = 1'b0; tick(3);

    // No preemption; next vector exactly HOLDOFF+2 cycles after ack
    tifr_in = 8'h01; timsk_in = 8'hFF; tick(1);
    tifr_in = 8'h81; tick(3);
    check("nopreempt_vec", vector_addr, 8'h16);
    irq_ack = 1'b1; tick(1);
    check("nopreempt_clr", flag_clear, 8'h01);
    irq_ack = 1'b0; tifr_in = 8'h80;
    tick(2);
    check("holdoff_quiet", 8'(irq_req), 8'h00);
    tick(1);
    check("holdoff_req", 8'(irq_req), 8'h01);
    check("holdoff_vec", vector_addr, 8'h08);
    irq_ack = 1'b1; tick(1);
    irq_ack = 1'b0; tifr_in = 8'h00; tick(3);

    // Async reset mid-REQUEST
    tifr_in = 8'h02; tick(1);
    check("pre_rst_vec", vector_addr, 8'h14);
    #3 system_reset = 1'b0;
    #1 check("rst_req_mid", 8'(irq_req), 8'h00);
    check("rst_vec_mid", vector_addr, 8'h00);
    tick(1);
    system_reset = 1'b1;
    tick(1);
    check("resume_vec", vector_addr, 8'h14);

    // Async reset mid-CLEAR
    irq_ack = 1'b1; tick(1);
    irq_ack = 1'b0;
    check("pre_rst_clr", flag_clear, 8'h02);
    #3 system_reset = 1'b0;
    #1 check("rst_clr_mid", flag_clear, 8'h00);
    check("rst_req_clr", 8'(irq_req), 8'h00);
    tick(1);
    system_reset = 1'b1; tifr_in = 8'h00;
    tick(4);

    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
